// File: rtl/seq_det_pkg.sv
// Shared constants and types for the time-multiplexed sequence detector.
// Channel state is sized for the largest supported pattern so that one
// struct type serves every PW instance; bits above PW stay at zero.
package seq_det_pkg;

  localparam int NCH_DEF = 4;   // default number of serial channels
  localparam int PW_DEF  = 8;   // default maximum pattern width
  localparam int PW_MAX  = 16;  // largest supported pattern width
  localparam int FW      = 5;   // fill-count width, holds 0..PW_MAX

  // Per-channel match history: shift register and saturating fill count.
  typedef struct packed {
    logic [PW_MAX-1:0] h;
    logic [FW-1:0]     f;
  } ch_state_t;

  // Mask with the low n bits set (n may equal PW_MAX).
  function automatic logic [PW_MAX-1:0] low_mask(input logic [FW-1:0] n);
    if (n >= FW'(PW_MAX)) begin
      low_mask = '1;
    end else begin
      low_mask = (PW_MAX'(1) << n) - PW_MAX'(1);
    end
  endfunction

endpackage

// File: rtl/seq_match_engine.sv
// Combinational single-bit step of a Mealy sequence detector. Takes one
// channel's stored history plus the incoming bit and returns the history
// to store back and whether this bit completed a match.
module seq_match_engine
  import seq_det_pkg::*;
#(
  parameter int PW = PW_DEF
) (
  input  logic [PW_MAX-1:0] h_i,
  input  logic [FW-1:0]     f_i,
  input  logic              b_i,
  input  logic [PW_MAX-1:0] pattern_i,
  input  logic [FW-1:0]     len_i,
  input  logic              overlap_i,
  output logic [PW_MAX-1:0] h_o,
  output logic [FW-1:0]     f_o,
  output logic              match_o
);

  logic [PW_MAX-1:0] hist_mask;
  logic [PW_MAX-1:0] len_mask;
  logic [PW_MAX-1:0] h_shift;
  logic [FW-1:0]     f_inc;

  // Shift in the new bit, saturate the fill count, compare the newest len bits.
  always_comb begin
    hist_mask = low_mask(FW'(PW));
    len_mask  = low_mask(len_i);
    h_shift   = ((h_i << 1) | PW_MAX'(b_i)) & hist_mask;
    f_inc     = (f_i >= FW'(PW)) ? FW'(PW) : f_i + 1'b1;
    match_o   = (len_i != '0) && (f_inc >= len_i) &&
                ((h_shift & len_mask) == (pattern_i & len_mask));
    if (match_o && !overlap_i) begin
      // Non-overlapping: the matched bits may not seed the next match.
      h_o = '0;
      f_o = '0;
    end else begin
      h_o = h_shift;
      f_o = f_inc;
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one match engine across NCH serial channels.
// Each channel keeps its own history, so it behaves like a private detector.
// One bit is consumed per cycle; match reporting is registered.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PW  = PW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [PW-1:0]            cfg_pattern,
  input  logic [$clog2(PW+1)-1:0]  cfg_len,
  input  logic                     cfg_overlap,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_bit,
  output logic [NCH-1:0]           ch_ready,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch,
  output logic [15:0]              match_total
);

  localparam int CW = $clog2(NCH);

  // Configuration registers
  logic [PW-1:0]  pattern_q;
  logic [FW-1:0]  len_q;
  logic           overlap_q;

  // Arbiter and per-channel state
  logic [CW-1:0]  ptr_q;
  ch_state_t      state_q [NCH];

  // Output registers
  logic           match_valid_q;
  logic [CW-1:0]  match_ch_q;
  logic [15:0]    match_total_q;

  // Combinational helpers
  logic           grant_any;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  ptr_d;
  logic [FW-1:0]  len_d;
  logic           fire;
  logic           grant_bit;
  ch_state_t      cur_state;
  logic [PW_MAX-1:0] eng_h;
  logic [FW-1:0]     eng_f;
  logic              eng_match;

  // Clamp the requested pattern length to the supported width.
  always_comb begin
    len_d = (FW'(cfg_len) > FW'(PW)) ? FW'(PW) : FW'(cfg_len);
  end

  // Round-robin search: first valid channel at or above the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!grant_any && ch_valid[(int'(ptr_q) + k) % NCH]) begin
        grant_any = 1'b1;
        grant_idx = CW'((int'(ptr_q) + k) % NCH);
      end
    end
  end

  // A config write blocks consumption for that cycle.
  assign fire      = grant_any && !cfg_we;
  assign grant_bit = ch_bit[grant_idx];
  assign cur_state = state_q[grant_idx];
  assign ptr_d     = (grant_idx == CW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot ready, held low during reset and config writes.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ready
      assign ch_ready[gi] = rst_n && fire && (grant_idx == CW'(gi));
    end
  endgenerate

  seq_match_engine #(
    .PW (PW)
  ) u_engine (
    .h_i       (cur_state.h),
    .f_i       (cur_state.f),
    .b_i       (grant_bit),
    .pattern_i (PW_MAX'(pattern_q)),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .h_o       (eng_h),
    .f_o       (eng_f),
    .match_o   (eng_match)
  );

  // Config load, history update, arbitration pointer and match reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q     <= '0;
      len_q         <= '0;
      overlap_q     <= 1'b0;
      ptr_q         <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= '0;
      end
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      match_total_q <= '0;
    end else if (cfg_we) begin
      // New config starts every channel from a clean history; pointer kept.
      pattern_q     <= cfg_pattern;
      len_q         <= len_d;
      overlap_q     <= cfg_overlap;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= '0;
      end
      match_valid_q <= 1'b0;
      match_total_q <= '0;
    end else if (fire) begin
      state_q[grant_idx].h <= eng_h;
      state_q[grant_idx].f <= eng_f;
      ptr_q                <= ptr_d;
      match_valid_q        <= eng_match;
      if (eng_match) begin
        match_ch_q <= grant_idx;
        if (match_total_q != 16'hFFFF) begin
          match_total_q <= match_total_q + 16'd1;
        end
      end
    end else begin
      match_valid_q <= 1'b0;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_total = match_total_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: directed scenarios plus
// randomized traffic, checked each cycle against a queue-based model.
module tb_seq_det_scheduler;

  localparam int NCH = 4;
  localparam int PW  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_bit;
  logic [3:0]  ch_ready;
  logic        match_valid;
  logic [1:0]  match_ch;
  logic [15:0] match_total;

  seq_det_scheduler #(.NCH(NCH), .PW(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .ch_valid    (ch_valid),
    .ch_bit      (ch_bit),
    .ch_ready    (ch_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .match_total (match_total)
  );

  always #5 clk = ~clk;

  // Reference model state: received bits per channel, newest at the back.
  int         m_ptr;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         hist [NCH][$];
  int         m_total;
  bit         exp_mv;
  int         exp_mch;
  int         last_g;
  bit         sq [NCH][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pat = '0; m_len = 0; m_ovl = 0;
    for (int i = 0; i < NCH; i++) hist[i].delete();
    m_total = 0; exp_mv = 0; exp_mch = 0; last_g = -1;
  endtask

  function automatic int model_grant();
    if (!rst_n || cfg_we) return -1;
    for (int k = 0; k < NCH; k++) begin
      if (ch_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  // One clock cycle: inputs already driven just after a falling edge.
  task automatic step();
    int g;
    bit ok;
    logic [3:0] exp_ready;
    #1;
    g = model_grant();
    exp_ready = (g < 0) ? 4'b0000 : 4'(1 << g);
    check("ch_ready", ch_ready, exp_ready);
    @(posedge clk);
    last_g = g;
    if (cfg_we) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > PW) ? PW : int'(cfg_len);
      m_ovl = cfg_overlap;
      for (int i = 0; i < NCH; i++) hist[i].delete();
      m_total = 0;
      exp_mv  = 0;
    end else if (g >= 0) begin
      hist[g].push_back(ch_bit[g]);
      if (hist[g].size() > PW) void'(hist[g].pop_front());
      ok = (m_len != 0) && (hist[g].size() >= m_len);
      for (int k = 0; k < m_len && ok; k++) begin
        if (hist[g][hist[g].size() - 1 - k] != m_pat[k]) ok = 0;
      end
      exp_mv = ok;
      if (ok) begin
        exp_mch = g;
        if (m_total < 65535) m_total++;
        if (!m_ovl) hist[g].delete();
      end
      m_ptr = (g + 1) % NCH;
    end else begin
      exp_mv = 0;
    end
    @(negedge clk);
    check("match_valid", match_valid, exp_mv);
    if (exp_mv) check("match_ch", match_ch, exp_mch);
    check("match_total", match_total, m_total);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  // Feed the per-channel bit queues until all are drained.
  task automatic run_streams();
    int guard = 0;
    bit busy = 1;
    while (busy && guard < 1000) begin
      busy = 0;
      for (int i = 0; i < NCH; i++) begin
        ch_valid[i] = (sq[i].size() > 0);
        ch_bit[i]   = (sq[i].size() > 0) ? sq[i][0] : 1'b0;
        if (sq[i].size() > 0) busy = 1;
      end
      if (busy) begin
        step();
        if (last_g >= 0) void'(sq[last_g].pop_front());
      end
      guard++;
    end
    check("stream_drained", 32'(busy), 32'd0);
    ch_valid = '0;
  endtask

  task automatic push_bits(input int ch, input logic [7:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) sq[ch].push_back(bits[k]);
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_ready", ch_ready, 4'b0000);
    check("rst_match_valid", match_valid, 1'b0);
    check("rst_match_ch", match_ch, 2'd0);
    check("rst_match_total", match_total, 16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_traffic(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!(ch_valid[i] && last_g != i)) begin
          ch_valid[i] = ($urandom_range(9) < 7);
          ch_bit[i]   = 1'($urandom_range(1));
        end
      end
      if ($urandom_range(49) == 0) begin
        cfg_pattern = 8'($urandom); cfg_len = 4'($urandom_range(5));
        cfg_overlap = 1'($urandom_range(1)); cfg_we = 1'b1;
      end
      step();
      cfg_we = 1'b0;
    end
    ch_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    ch_valid = 4'hF; ch_bit = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_ready", ch_ready, 4'b0000);
    check("reset_match_valid", match_valid, 1'b0);
    check("reset_match_ch", match_ch, 2'd0);
    check("reset_match_total", match_total, 16'd0);
    ch_valid = '0;
    rst_n = 1'b1;

    // Overlapping detection of 1010 on ch0
    do_cfg(8'b0000_1010, 4'd4, 1'b1);
    push_bits(0, 8'b0010_1010, 6);
    run_streams();
    check("ovl_total", match_total, 16'd2);

    // Non-overlapping detection of 1010 on ch0
    do_cfg(8'b0000_1010, 4'd4, 1'b0);
    push_bits(0, 8'b1010_1010, 8);
    run_streams();
    check("nonovl_total", match_total, 16'd2);

    // Round-robin rotation from pointer 0, then ch1 dropped
    do_reset();
    ch_valid = 4'hF; ch_bit = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_seq", 32'(last_g), 32'(k % NCH));
    end
    ch_valid = 4'b1101;
    repeat (4) step();
    ch_valid = '0;

    // Interleaved ch1/ch2, histories must stay separate
    do_cfg(8'b0000_1010, 4'd4, 1'b1);
    push_bits(1, 8'b0000_1010, 4);
    push_bits(2, 8'b0000_1010, 4);
    run_streams();
    check("interleave_total", match_total, 16'd2);

    // Config write clears a partially matched history
    do_cfg(8'b0000_1010, 4'd4, 1'b1);
    push_bits(0, 8'b0000_0101, 3);
    run_streams();
    do_cfg(8'b0000_1010, 4'd4, 1'b1);
    push_bits(0, 8'b0000_0000, 1);
    run_streams();
    check("cfgclr_total", match_total, 16'd0);
    push_bits(0, 8'b0000_1010, 4);
    run_streams();
    check("cfgclr_after", match_total, 16'd1);

    // Length zero never matches
    do_cfg(8'($urandom), 4'd0, 1'b1);
    random_traffic(150);

    // Reset in the middle of traffic, then resume
    do_cfg(8'b0000_0011, 4'd2, 1'b1);
    ch_valid = 4'hF; ch_bit = 4'hF;
    repeat (6) step();
    do_reset();
    repeat (3) step();
    ch_valid = '0;

    // Randomized traffic, including lengths that clamp to PW
    for (int r = 0; r < 4; r++) begin
      do_cfg(8'($urandom), (r == 3) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(1, 4)),
             1'($urandom_range(1)));
      random_traffic(400);
    end

    // Saturation: a 1-bit pattern matches on every consumed bit
    do_cfg(8'h01, 4'd1, 1'b1);
    ch_valid = 4'hF; ch_bit = 4'hF;
    repeat (65540) step();
    ch_valid = '0;
    check("sat_total", match_total, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: got no finish expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Time-multiplexed pattern-detection controller: arbitrates NCH serial bit channels onto one shared matching engine, one bit per cycle, round-robin. Per-channel match history lives here, so each channel behaves as if it had a private Mealy sequence detector. Pattern, length and overlap mode are software-configurable. It sits between the serial front-ends and the event/interrupt logic, replacing per-channel hard-coded detectors.

## Interface
- NCH, 4, number of serial channels (2..8)
- PW, 8, maximum pattern width in bits (2..16)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  load config and clear all channel histories
- cfg_pattern  in  PW  pattern; bit [len-1] is the first bit received, bit 0 the last
- cfg_len  in  $clog2(PW+1)  pattern length; 0 disables matching; values > PW clamp to PW
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping detection
- ch_valid  in  NCH  per-channel bit available
- ch_bit  in  NCH  per-channel serial data bit
- ch_ready  out  NCH  one-hot grant; a bit is consumed when ch_valid[i] & ch_ready[i]
- match_valid  out  1  one-cycle pulse: the consumed bit completed a match
- match_ch  out  $clog2(NCH)  channel of the match; valid with match_valid
- match_total  out  16  saturating count of all matches since reset/cfg_we

## Operation
- Registered config: pattern, len (clamped), overlap. Reset: pattern 0, len 0, overlap 0.
- Per channel: history h[PW-1:0] and fill count f (0..PW, saturating). Reset/cfg_we: all zero.
- Arbitration: a round-robin pointer names the highest-priority channel. Grant goes to the first channel with ch_valid set, searching upward from the pointer with wrap. After a grant, pointer = granted+1 (mod NCH). No valid channel: no grant, pointer unchanged. Reset pointer: 0.
- ch_ready is combinational from ch_valid and the pointer, and is at most one-hot. It is all-zero while cfg_we = 1.
- Engine for granted channel g with bit b: h' = {h[PW-2:0], b}, f' = min(f+1, PW).
- Match when len != 0, f' >= len, and h'[len-1:0] == pattern[len-1:0].
- On match with overlap = 1: store h', f'. With overlap = 0: store h = 0, f = 0.
- No match: store h', f'.
- match_total increments on each match and saturates at 16'hFFFF.
- cfg_we: the config loads at the edge; all h, f and match_total clear; the pointer does not change. No bit is consumed that cycle.
- Reset mid-operation: all state returns to reset values immediately (async). The first grant after release comes from the pointer at 0.

## Timing
- Handshake is accept-on-edge. A channel may hold ch_valid across cycles. ch_bit must be stable while ch_valid is high and not yet accepted.
- Sustained throughput: 1 bit/cycle total. With all channels valid, each channel gets 1 bit per NCH cycles.
- Match latency: match_valid and match_ch are registered. They assert in the cycle after the edge that accepted the completing bit.
- Reset values: ch_ready 0, match_valid 0, match_ch 0, match_total 0.
- cfg_we asserted in the same cycle as a pending match pulse: the pulse still appears, and match_total clears.

## Structure
- Package seq_det_pkg holds the default NCH/PW constants and the channel-state struct typedef {h, f}.
- Sub-module seq_match_engine is combinational. Inputs: h, f, b, pattern, len, overlap. Outputs: next h, next f, match.
- The scheduler holds the rr arbiter, per-channel state array, config registers, output registers and counter.

## Test plan
- Ch0 only, pattern 4'b1010, len 4, overlap 1, bits 1,0,1,0,1,0 -> match_valid with match_ch 0 after bits 4 and 6; match_total = 2.
- Same stream with overlap 0, plus 1,0 appended -> matches after bits 4 and 8 only; match_total = 2.
- All 4 ch_valid held high -> ch_ready sequence 0001, 0010, 0100, 1000, 0001. Then drop ch1 -> it is skipped with no idle cycle.
- Ch1 and ch2 interleaved, each sending 1,0,1,0 -> two matches, match_ch 1 then 2. Histories must not cross-contaminate.
- cfg_we after ch0 has sent 1,0,1 -> ch0 then sends 0 -> no match; 1,0,1,0 afterwards -> match. cfg_len = 0 -> no matches ever.
- rst_n pulsed mid-stream -> outputs at reset values; histories cleared. Also force match_total to 16'hFFFF via a long stream -> it stays at 16'hFFFF.
